// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the default register-address width.
package pipeline_hazard_controller_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX-resolved
// redirects, data-memory waits, plus stall/flush performance counters.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W   = REG_ADDR_W_DEFAULT,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rs_i,
    input  logic                  id_uses_rt_i,
    input  logic                  idex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] idex_write_register_i,
    input  logic                  ex_branch_taken_i,
    input  logic                  ex_jmp_i,
    input  logic                  mem_busy_i,
    input  logic                  clear_counters_i,
    output logic                  pc_enable_o,
    output logic                  ifid_enable_o,
    output logic                  ifid_flush_o,
    output logic                  idex_enable_o,
    output logic                  idex_flush_o,
    output logic                  exmem_enable_o,
    output logic                  pc_redirect_o,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_count_o,
    output logic [CNT_W-1:0]      flush_count_o
);

    localparam logic [2:0] BUBBLE_LOAD = 3'(LOAD_BUBBLES - 1);

    state_t     state, state_next;
    logic [2:0] bcnt, bcnt_next;
    logic       hz, rd, take_stall, take_run;
    logic       pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, redirect;

    assign hz = idex_mem_read_i && (idex_write_register_i != '0) &&
                ((id_uses_rs_i && (id_rs_i == idex_write_register_i)) ||
                 (id_uses_rt_i && (id_rt_i == idex_write_register_i)));
    assign rd = ex_branch_taken_i || ex_jmp_i;

    // A wait that interrupted a bubble sequence resumes the bubbles on exit
    assign take_stall = (state == LOAD_STALL) || ((state == MEM_WAIT) && (bcnt != 3'd0));
    assign take_run   = (state == RUN)        || ((state == MEM_WAIT) && (bcnt == 3'd0));

    always_comb begin
        state_next = state;
        bcnt_next  = bcnt;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_fl    = 1'b0;
        idex_en    = 1'b1;
        idex_fl    = 1'b0;
        exmem_en   = 1'b1;
        redirect   = 1'b0;
        if (mem_busy_i) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            state_next = MEM_WAIT;
        end else if (take_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_fl    = 1'b1;
            bcnt_next  = (bcnt == 3'd0) ? 3'd0 : bcnt - 3'd1;
            state_next = (bcnt <= 3'd1) ? RUN : LOAD_STALL;
        end else if (take_run && rd) begin
            ifid_fl    = 1'b1;
            idex_fl    = 1'b1;
            redirect   = 1'b1;
            state_next = RUN;
        end else if (take_run && hz) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_fl    = 1'b1;
            bcnt_next  = BUBBLE_LOAD;
            state_next = (LOAD_BUBBLES > 1) ? LOAD_STALL : RUN;
        end else begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            bcnt  <= 3'd0;
        end else begin
            state <= state_next;
            bcnt  <= bcnt_next;
        end
    end

    // Reset forces every control low combinationally, not just at the next edge
    assign pc_enable_o    = reset & pc_en;
    assign ifid_enable_o  = reset & ifid_en;
    assign ifid_flush_o   = reset & ifid_fl;
    assign idex_enable_o  = reset & idex_en;
    assign idex_flush_o   = reset & idex_fl;
    assign exmem_enable_o = reset & exmem_en;
    assign pc_redirect_o  = reset & redirect;
    assign state_o        = state;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~pc_enable_o),
        .clr   (clear_counters_i),
        .count (stall_count_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_redirect_o),
        .clr   (clear_counters_i),
        .count (flush_count_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: expected control vectors are
// queued as stimulus is driven and compared when sampled mid-cycle.
module tb_pipeline_hazard_controller;

    localparam int RW = 5;
    localparam int CW = 4;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, redirect}
    localparam logic [6:0] C_RUN    = 7'b1101010;
    localparam logic [6:0] C_REDIR  = 7'b1111111;
    localparam logic [6:0] C_STALL  = 7'b0001110;
    localparam logic [6:0] C_FROZEN = 7'b0000000;

    typedef struct packed {
        logic [6:0] ctl;
        logic [1:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [RW-1:0] id_rs = '0, id_rt = '0, wr = '0;
    logic urs = 1'b0, urt = 1'b0, mr = 1'b0, br = 1'b0, jmp = 1'b0;
    logic busy = 1'b0, clr = 1'b0;
    logic sel = 1'b0;

    logic [6:0]    ctl1, ctl3;
    logic [1:0]    st1, st3;
    logic [CW-1:0] sc1, sc3, fc1, fc3;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.REG_ADDR_W(RW), .LOAD_BUBBLES(1), .CNT_W(CW)) dut1 (
        .clk(clk), .reset(reset), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rs_i(urs), .id_uses_rt_i(urt), .idex_mem_read_i(mr),
        .idex_write_register_i(wr), .ex_branch_taken_i(br), .ex_jmp_i(jmp),
        .mem_busy_i(busy), .clear_counters_i(clr),
        .pc_enable_o(ctl1[6]), .ifid_enable_o(ctl1[5]), .ifid_flush_o(ctl1[4]),
        .idex_enable_o(ctl1[3]), .idex_flush_o(ctl1[2]), .exmem_enable_o(ctl1[1]),
        .pc_redirect_o(ctl1[0]), .state_o(st1), .stall_count_o(sc1), .flush_count_o(fc1)
    );

    pipeline_hazard_controller #(.REG_ADDR_W(RW), .LOAD_BUBBLES(3), .CNT_W(CW)) dut3 (
        .clk(clk), .reset(reset), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rs_i(urs), .id_uses_rt_i(urt), .idex_mem_read_i(mr),
        .idex_write_register_i(wr), .ex_branch_taken_i(br), .ex_jmp_i(jmp),
        .mem_busy_i(busy), .clear_counters_i(clr),
        .pc_enable_o(ctl3[6]), .ifid_enable_o(ctl3[5]), .ifid_flush_o(ctl3[4]),
        .idex_enable_o(ctl3[3]), .idex_flush_o(ctl3[2]), .exmem_enable_o(ctl3[1]),
        .pc_redirect_o(ctl3[0]), .state_o(st3), .stall_count_o(sc3), .flush_count_o(fc3)
    );

    wire [6:0]    obs_ctl = sel ? ctl3 : ctl1;
    wire [1:0]    obs_st  = sel ? st3  : st1;
    wire [CW-1:0] obs_sc  = sel ? sc3  : sc1;
    wire [CW-1:0] obs_fc  = sel ? fc3  : fc1;

    task automatic compare(input string tag, input exp_t e);
        checks++;
        assert (obs_ctl === e.ctl) else begin
            errors++;
            $error("FAIL %s ctl: observed=%b expected=%b", tag, obs_ctl, e.ctl);
        end
        checks++;
        assert (obs_st === e.st) else begin
            errors++;
            $error("FAIL %s state: observed=%0d expected=%0d", tag, obs_st, e.st);
        end
        checks++;
        assert (obs_sc === CW'(exp_stall)) else begin
            errors++;
            $error("FAIL %s stall_count: observed=%0d expected=%0d", tag, obs_sc, exp_stall);
        end
        checks++;
        assert (obs_fc === CW'(exp_flush)) else begin
            errors++;
            $error("FAIL %s flush_count: observed=%0d expected=%0d", tag, obs_fc, exp_flush);
        end
    endtask

    // Inputs are already driven; check this cycle mid-period, then advance one cycle.
    task automatic cyc(input string tag, input logic [6:0] ctl, input logic [1:0] st);
        exp_t e;
        q.push_back('{ctl: ctl, st: st});
        @(negedge clk);
        e = q.pop_front();
        compare(tag, e);
        if (clr) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (!e.ctl[6] && exp_stall < (1 << CW) - 1) exp_stall++;
            if (e.ctl[0]  && exp_flush < (1 << CW) - 1) exp_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        exp_t e;
        exp_stall = 0;
        exp_flush = 0;
        q.push_back('{ctl: C_FROZEN, st: 2'd0});
        e = q.pop_front();
        compare(tag, e);
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; wr = '0;
        urs = 1'b0; urt = 1'b0; mr = 1'b0;
        br = 1'b0; jmp = 1'b0; busy = 1'b0; clr = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        sel = 1'b0;
        @(posedge clk);
        #1;
        check_reset("reset_dut1");
        @(posedge clk);
        #1;
        reset = 1'b1;

        cyc("idle", C_RUN, 2'd0);

        // No hazard: destination $0, or rs not actually read
        mr = 1'b1; wr = 5'd0; id_rs = 5'd0; urs = 1'b1;
        cyc("no_hz_r0", C_RUN, 2'd0);
        wr = 5'd8; id_rs = 5'd8; urs = 1'b0;
        cyc("no_hz_unused", C_RUN, 2'd0);

        // Load-use on rs, single bubble
        urs = 1'b1;
        cyc("hz_rs", C_STALL, 2'd0);
        idle();
        cyc("after_hz_rs", C_RUN, 2'd0);

        // Load-use on rt
        mr = 1'b1; wr = 5'd9; id_rs = 5'd3; urs = 1'b1; id_rt = 5'd9; urt = 1'b1;
        cyc("hz_rt", C_STALL, 2'd0);
        idle();
        cyc("after_hz_rt", C_RUN, 2'd0);

        // Redirect beats hazard
        mr = 1'b1; wr = 5'd8; id_rs = 5'd8; urs = 1'b1; br = 1'b1;
        cyc("br_over_hz", C_REDIR, 2'd0);
        idle();
        cyc("after_br", C_RUN, 2'd0);

        // Memory wait with a taken branch frozen in EX
        br = 1'b1; busy = 1'b1;
        cyc("busy1", C_FROZEN, 2'd0);
        cyc("busy2", C_FROZEN, 2'd2);
        cyc("busy3", C_FROZEN, 2'd2);
        busy = 1'b0;
        cyc("busy_exit_redir", C_REDIR, 2'd2);
        idle();
        cyc("after_busy", C_RUN, 2'd0);

        jmp = 1'b1;
        cyc("jmp", C_REDIR, 2'd0);

        // Flush counter saturation
        jmp = 1'b0; br = 1'b1;
        for (int i = 0; i < 14; i++) cyc("br_sat", C_REDIR, 2'd0);
        idle();
        cyc("flush_sat", C_RUN, 2'd0);

        // Clear wins over a same-cycle redirect
        br = 1'b1; clr = 1'b1;
        cyc("clr_with_br", C_REDIR, 2'd0);
        idle();
        cyc("after_clr", C_RUN, 2'd0);

        // Three-bubble instance
        sel = 1'b1;
        reset = 1'b0;
        #1;
        check_reset("reset_dut3");
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc("idle3", C_RUN, 2'd0);

        mr = 1'b1; wr = 5'd8; id_rs = 5'd8; urs = 1'b1;
        cyc("lb3_b1", C_STALL, 2'd0);
        idle();
        busy = 1'b1;
        cyc("lb3_busy1", C_FROZEN, 2'd1);
        cyc("lb3_busy2", C_FROZEN, 2'd2);
        busy = 1'b0;
        cyc("lb3_b2", C_STALL, 2'd2);
        cyc("lb3_b3", C_STALL, 2'd1);
        cyc("lb3_done", C_RUN, 2'd0);

        // Reset in the middle of a bubble sequence
        mr = 1'b1; wr = 5'd8; id_rs = 5'd8; urs = 1'b1;
        cyc("lb3r_b1", C_STALL, 2'd0);
        idle();
        cyc("lb3r_b2", C_STALL, 2'd1);
        reset = 1'b0;
        #1;
        check_reset("mid_stall_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc("after_mid_reset", C_RUN, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
